// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, runs the imem request/ready handshake and holds the fetched word for the decoder.
// Optional INSTR_FETCH_ALIGN_CHECK_EN: misaligned jr raises sticky addr_err and halts until reset.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [1:0]  Jump,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        , S_HALT
`endif
    } state_t;

    state_t      state;
    logic [31:0] next_pc;

    // Low jr bits and the top offset bits fall off the shifted arithmetic.
    logic unused_bits;
    assign unused_bits = ^{jr_target[1:0], branch_offset[31:30]};

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    // Gated by reset_n so the request drops the instant reset asserts.
    assign imem_req  = reset_n && ((state == S_REQ) || (state == S_WAIT));

    always_comb begin
        next_pc = pc_plus4;
        if (Jump == 2'b01)
            next_pc = {jr_target[31:2], 2'b00};
        else if (Jump[1])
            next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
        else if (branch_taken)
            next_pc = pc_plus4 + {branch_offset[29:0], 2'b00};
    end

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic misaligned_jr;
    assign misaligned_jr = (Jump == 2'b01) && (jr_target[1:0] != 2'b00);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            addr_err <= 1'b0;
        else if (state == S_HOLD && !stall && misaligned_jr)
            addr_err <= 1'b1;
    end
`else
    assign addr_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instruction <= NOP_WORD;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ, S_WAIT: begin
                    if (imem_ready) begin
                        instruction <= imem_data;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        state       <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instruction <= NOP_WORD;
                        instr_valid <= 1'b0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
                        if (misaligned_jr) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= S_REQ;
                        end
`else
                        pc          <= next_pc;
                        state       <= S_REQ;
`endif
                    end
                end
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
                S_HALT: state <= S_HALT;
`endif
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stimulus pushes expected fetches to a scoreboard, a negedge monitor pops and checks.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [1:0]  Jump;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic [31:0] jr_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_err;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } exp_t;
    exp_t exp_q[$];

    logic        pend = 1'b0;
    logic [31:0] pend_word;

    instr_fetch dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .Jump(Jump),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jr_target(jr_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_ready(imem_ready), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4), .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a request accepted on this cycle must match the next scoreboard entry,
    // and the following cycle must present that word as a valid instruction.
    always @(negedge clock) begin
        if (pend) begin
            chk("instr_valid after accept", {31'd0, instr_valid}, 32'd1);
            chk("held instruction", instruction, pend_word);
            pend = 1'b0;
        end
        if (reset_n && imem_req && imem_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected fetch: got addr %h, expected none", imem_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("fetch addr", imem_addr, e.addr);
                pend      = 1'b1;
                pend_word = e.word;
            end
        end
    end

    // One fetch: wait states, then accept, then stall cycles in HOLD with the redirect applied.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int waits,
                         input int stalls, input logic [1:0] jmp, input logic bt,
                         input logic [31:0] boff, input logic [31:0] jrt);
        int req_cnt;
        int hold_cnt;
        exp_q.push_back('{addr, word});
        for (int i = 0; i < 20 && !imem_req; i++) @(posedge clock) #1;
        if (!imem_req) begin
            vectors++;
            errors++;
            $display("FAIL fetch timeout: got no imem_req, expected request for %h", addr);
            return;
        end
        req_cnt = 0;
        imem_ready = 1'b0;
        for (int i = 0; i < waits; i++) begin
            if (imem_req && imem_addr == addr) req_cnt++;
            @(posedge clock) #1;
        end
        imem_ready = 1'b1;
        imem_data  = word;
        Jump = jmp; branch_taken = bt; branch_offset = boff; jr_target = jrt;
        if (imem_req && imem_addr == addr) req_cnt++;
        @(posedge clock) #1;
        imem_ready = 1'b0;
        chk("pc while held", pc, addr);
        chk("pc_plus4 while held", pc_plus4, addr + 32'd4);
        hold_cnt = 0;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            if (instr_valid && !imem_req && instruction == word) hold_cnt++;
            @(posedge clock) #1;
        end
        stall = 1'b0;
        if (instr_valid && !imem_req && instruction == word) hold_cnt++;
        @(posedge clock) #1;
        Jump = 2'b00; branch_taken = 1'b0; branch_offset = 32'd0; jr_target = 32'd0;
        chk("request cycles", req_cnt, waits + 1);
        chk("hold cycles", hold_cnt, stalls + 1);
        chk("instr_valid cleared", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b1; stall = 1'b0; Jump = 2'b00; branch_taken = 1'b0;
        branch_offset = 32'd0; jr_target = 32'd0; imem_data = 32'd0; imem_ready = 1'b0;

        // Reset asserted between edges must act immediately.
        #2 reset_n = 1'b0;
        #1;
        chk("reset pc", pc, 32'h0);
        chk("reset instruction", instruction, 32'h0);
        chk("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset imem_req", {31'd0, imem_req}, 32'd0);
        chk("reset addr_err", {31'd0, addr_err}, 32'd0);
        @(posedge clock); @(posedge clock) #1;
        reset_n = 1'b1;

        fetch(32'h0000_0000, 32'h2402_0001, 0, 0, 2'b00, 1'b0, 32'd0, 32'd0);
        fetch(32'h0000_0004, 32'h2403_0002, 0, 0, 2'b00, 1'b0, 32'd0, 32'd0);
        fetch(32'h0000_0008, 32'h0120_0008, 0, 0, 2'b01, 1'b0, 32'd0, 32'h0000_0010);
        fetch(32'h0000_0010, 32'h0043_2020, 3, 2, 2'b00, 1'b0, 32'd0, 32'd0);
        fetch(32'h0000_0014, 32'h0140_0008, 0, 0, 2'b01, 1'b0, 32'd0, 32'h0000_1000);
        fetch(32'h0000_1000, 32'h0800_0040, 0, 0, 2'b10, 1'b0, 32'd0, 32'd0);
        fetch(32'h0000_0100, 32'h1043_FFFE, 0, 0, 2'b00, 1'b1, 32'hFFFF_FFFE, 32'd0);
        fetch(32'h0000_00FC, 32'h0160_0008, 1, 0, 2'b01, 1'b0, 32'd0, 32'h0000_2000);
        fetch(32'h0000_2000, 32'h0800_0080, 0, 1, 2'b10, 1'b1, 32'h0000_0010, 32'd0);
        fetch(32'h0000_0200, 32'h0C00_0400, 0, 0, 2'b11, 1'b0, 32'd0, 32'd0);

        // Abort a fetch of 0x1000 in WAIT; the restart must come from RESET_PC.
        chk("req before abort", imem_addr, 32'h0000_1000);
        @(posedge clock) #1;
        reset_n = 1'b0;
        #1;
        chk("abort imem_req", {31'd0, imem_req}, 32'd0);
        chk("abort pc", pc, 32'h0);
        @(posedge clock) #1;
        reset_n = 1'b1;

        fetch(32'h0000_0000, 32'h0180_0008, 0, 0, 2'b01, 1'b0, 32'd0, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h2404_0003, 0, 0, 2'b00, 1'b0, 32'd0, 32'd0);
        fetch(32'h0000_0000, 32'h01A0_0008, 0, 0, 2'b01, 1'b0, 32'd0, 32'h0000_2002);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("halt addr_err", {31'd0, addr_err}, 32'd1);
            chk("halt imem_req", {31'd0, imem_req}, 32'd0);
            chk("halt instr_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt pc", pc, 32'h0);
            @(posedge clock) #1;
        end
        imem_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("addr_err cleared", {31'd0, addr_err}, 32'd0);
        @(posedge clock) #1;
        reset_n = 1'b1;
        fetch(32'h0000_0000, 32'h2405_0004, 0, 0, 2'b00, 1'b0, 32'd0, 32'd0);
`else
        chk("addr_err tied low", {31'd0, addr_err}, 32'd0);
        fetch(32'h0000_2000, 32'h2405_0004, 0, 0, 2'b00, 1'b0, 32'd0, 32'd0);
`endif
        @(posedge clock) #1;
        chk("scoreboard drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
